// File: rtl/lfsr_sample_source_pkg.sv
// lfsr_sample_source_pkg: shared state encodings and default LFSR constants for the sample source.
package lfsr_sample_source_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;
  localparam logic [15:0] LFSR_TAPS_DEFAULT = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois: Galois LFSR that advances one step per i_step; SEED must be nonzero.
module lfsr_galois #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = 16'hB400,
  parameter logic [WIDTH-1:0] SEED = 16'hACE1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_step,
  output logic [WIDTH-1:0] ov_state
);
  logic [WIDTH-1:0] state_q, state_d;
  always_comb state_d = i_step ? ((state_q >> 1) ^ (state_q[0] ? TAPS : '0)) : state_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state_q <= SEED;
    else          state_q <= state_d;
  assign ov_state = state_q;
endmodule

// File: rtl/lfsr_sample_source.sv
// lfsr_sample_source: streams LFSR words MSB-first over a valid/ready serial link.
module lfsr_sample_source
  import lfsr_sample_source_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COUNT_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS = LFSR_TAPS_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_start,
  input  logic [COUNT_WIDTH-1:0] iv_num_words,
  input  logic                   i_ready,
  output logic                   o_dout,
  output logic                   o_dout_valid,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [COUNT_WIDTH-1:0] ov_words_sent
);
  localparam int BW = $clog2(DATA_WIDTH);
  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d, lfsr_state;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [COUNT_WIDTH-1:0] words_q, words_d, num_q, num_d, words_inc;
  logic                   busy_q, busy_d, done_q, done_d, lfsr_step;

  lfsr_galois #(.WIDTH(DATA_WIDTH), .TAPS(LFSR_TAPS), .SEED(LFSR_SEED)) u_lfsr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_step   (lfsr_step),
    .ov_state (lfsr_state)
  );

  assign words_inc = words_q + COUNT_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    words_d   = words_q;
    num_d     = num_q;
    lfsr_step = 1'b0;
    if (i_en)
      case (state_q)
        IDLE: if (i_start) begin
          words_d = '0;
          num_d   = iv_num_words;
          state_d = (iv_num_words == '0) ? DONE : LOAD;
        end
        LOAD: begin
          shift_d   = lfsr_state;
          lfsr_step = 1'b1;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
        SHIFT: if (i_ready) begin
          shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            words_d = words_inc;
            state_d = (words_inc == num_q) ? DONE : LOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      words_q   <= '0;
      num_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      words_q   <= words_d;
      num_q     <= num_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end

  // Valid is the only combinational output so that i_en can stall the link in the same cycle.
  assign o_dout_valid  = (state_q == SHIFT) && i_en;
  assign o_dout        = shift_q[DATA_WIDTH-1];
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign ov_words_sent = words_q;
endmodule

// File: tb/tb_lfsr_sample_source.sv
// tb_lfsr_sample_source: directed scenarios for the LFSR serial sample source.
module tb_lfsr_sample_source;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num = '0;
  logic        rdy = 1'b1;
  logic        dout, dout_valid, busy, done;
  logic [15:0] words_sent;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic bits[$];
  logic vhist[0:255];
  int   done_cyc;
  logic busy_c1, valid_seen, en_low_valid, stall_changed;

  always #5 clk = ~clk;

  lfsr_sample_source dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_start       (start),
    .iv_num_words  (num),
    .i_ready       (rdy),
    .o_dout        (dout),
    .o_dout_valid  (dout_valid),
    .o_busy        (busy),
    .o_done        (done),
    .ov_words_sent (words_sent)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b1;
    start = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts a run (start sampled on edge 0) and records what the link carries, cycle by cycle.
  task automatic collect(input logic [15:0] n, input int ready_mode, input int en_drop, input int abort_bits);
    logic prev_stall, stall_bit;
    bits.delete();
    for (int i = 0; i < 256; i++) vhist[i] = 1'b0;
    done_cyc = -1;
    busy_c1 = 1'b0;
    valid_seen = 1'b0;
    en_low_valid = 1'b0;
    stall_changed = 1'b0;
    prev_stall = 1'b0;
    stall_bit = 1'b0;
    @(posedge clk);
    #1;
    num = n;
    start = 1'b1;
    rdy = 1'b1;
    en = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      #1;
      start = 1'b0;
      rdy = (ready_mode == 1) ? c[0] : 1'b1;
      en = !(en_drop > 0 && c >= en_drop && c < en_drop + 5);
      @(negedge clk);
      if (c == 1) busy_c1 = busy;
      if (c < 256) vhist[c] = dout_valid;
      if (dout_valid) valid_seen = 1'b1;
      if (!en && dout_valid) en_low_valid = 1'b1;
      if (prev_stall && dout_valid && dout !== stall_bit) stall_changed = 1'b1;
      prev_stall = dout_valid && !rdy;
      stall_bit = dout;
      if (abort_bits > 0 && dout_valid && bits.size() == abort_bits) begin
        rst_n = 1'b0;
        break;
      end
      if (dout_valid && rdy) bits.push_back(dout);
      if (done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk);
    end
    en = 1'b1;
    rdy = 1'b1;
  endtask

  function automatic logic [15:0] word_at(input int k);
    logic [15:0] w;
    if (bits.size() < 16 * (k + 1)) return 16'hxxxx;
    for (int i = 0; i < 16; i++) w[15-i] = bits[16*k+i];
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({dout, dout_valid, busy, done, words_sent} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h want 00000", {dout, dout_valid, busy, done, words_sent});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    do_reset();
    collect(16'd1, 0, 0, 0);
    n_cmp++;
    if (busy_c1 !== 1'b1) begin n_bad++; $display("FAIL single_busy_rise got %b want 1", busy_c1); end
    n_cmp++;
    if (word_at(0) !== 16'hACE1) begin n_bad++; $display("FAIL single_word got %h want ace1", word_at(0)); end
    n_cmp++;
    if (bits.size() != 16) begin n_bad++; $display("FAIL single_bitcount got %0d want 16", bits.size()); end
    n_cmp++;
    if (vhist[1] !== 1'b0 || vhist[2] !== 1'b1) begin n_bad++; $display("FAIL single_first_valid got c1=%b c2=%b want 0 1", vhist[1], vhist[2]); end
    n_cmp++;
    if (done_cyc != 18) begin n_bad++; $display("FAIL single_done_cycle got %0d want 18", done_cyc); end
    n_cmp++;
    if (words_sent !== 16'd1) begin n_bad++; $display("FAIL single_words_sent got %0d want 1", words_sent); end
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL single_after_done busy/done got %b want 00", {busy, done}); end
  endtask

  task automatic test_two_words();
    do_reset();
    collect(16'd2, 0, 0, 0);
    n_cmp++;
    if (word_at(0) !== 16'hACE1 || word_at(1) !== 16'hE270) begin
      n_bad++;
      $display("FAIL two_words got %h %h want ace1 e270", word_at(0), word_at(1));
    end
    n_cmp++;
    if ({vhist[17], vhist[18], vhist[19]} !== 3'b101) begin
      n_bad++;
      $display("FAIL two_bubble got %b want 101", {vhist[17], vhist[18], vhist[19]});
    end
    n_cmp++;
    if (done_cyc != 35) begin n_bad++; $display("FAIL two_done_cycle got %0d want 35", done_cyc); end
    n_cmp++;
    if (words_sent !== 16'd2) begin n_bad++; $display("FAIL two_words_sent got %0d want 2", words_sent); end
  endtask

  task automatic test_backpressure();
    do_reset();
    collect(16'd1, 1, 0, 0);
    n_cmp++;
    if (word_at(0) !== 16'hACE1 || bits.size() != 16) begin
      n_bad++;
      $display("FAIL bp_word got %h (%0d bits) want ace1 (16 bits)", word_at(0), bits.size());
    end
    n_cmp++;
    if (stall_changed !== 1'b0) begin n_bad++; $display("FAIL bp_stall_stable got changed=%b want 0", stall_changed); end
    n_cmp++;
    if (done_cyc != 34) begin n_bad++; $display("FAIL bp_done_cycle got %0d want 34", done_cyc); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    collect(16'd1, 0, 8, 0);
    n_cmp++;
    if (en_low_valid !== 1'b0) begin n_bad++; $display("FAIL en_valid_gated got %b want 0", en_low_valid); end
    n_cmp++;
    if (word_at(0) !== 16'hACE1 || bits.size() != 16) begin
      n_bad++;
      $display("FAIL en_word got %h (%0d bits) want ace1 (16 bits)", word_at(0), bits.size());
    end
    n_cmp++;
    if (done_cyc != 23) begin n_bad++; $display("FAIL en_done_cycle got %0d want 23", done_cyc); end
  endtask

  task automatic test_zero_words();
    do_reset();
    collect(16'd0, 0, 0, 0);
    n_cmp++;
    if (done_cyc != 1) begin n_bad++; $display("FAIL zero_done_cycle got %0d want 1", done_cyc); end
    n_cmp++;
    if (valid_seen !== 1'b0) begin n_bad++; $display("FAIL zero_no_valid got %b want 0", valid_seen); end
    n_cmp++;
    if (words_sent !== 16'd0) begin n_bad++; $display("FAIL zero_words_sent got %0d want 0", words_sent); end
    collect(16'd1, 0, 0, 0);
    n_cmp++;
    if (word_at(0) !== 16'hACE1) begin n_bad++; $display("FAIL zero_then_one got %h want ace1", word_at(0)); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    collect(16'd2, 0, 0, 23);
    n_cmp++;
    if (rst_n !== 1'b0) begin n_bad++; $display("FAIL midrst_reached got rst_n=%b want 0", rst_n); end
    #1;
    n_cmp++;
    if ({dout, dout_valid, busy, done, words_sent} !== 20'h0) begin
      n_bad++;
      $display("FAIL midrst_outputs got %h want 00000", {dout, dout_valid, busy, done, words_sent});
    end
    #2;
    rst_n = 1'b1;
    collect(16'd1, 0, 0, 0);
    n_cmp++;
    if (word_at(0) !== 16'hACE1) begin n_bad++; $display("FAIL midrst_reseed got %h want ace1", word_at(0)); end
    n_cmp++;
    if (done_cyc != 18) begin n_bad++; $display("FAIL midrst_done_cycle got %0d want 18", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_backpressure();
    test_enable_drop();
    test_zero_words();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
